// File: rtl/rs232_tx_encoder.sv
// rs232_tx_encoder: buffered UART transmitter for the RS-232 command link.
// Accepts bytes on a valid/ready interface into a small FIFO and serialises
// each one as start bit, 8 data bits LSB first, optional even parity, then
// 1 or 2 stop bits. The baud timing comes from a divider on the system clock.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-low reset
//   tx_byte    byte to transmit
//   tx_valid   tx_byte is valid this cycle
//   tx_ready   FIFO can accept a byte this cycle (registered)
//   tx         serial line, idle high (registered)
//   busy       FIFO non-empty or a frame in progress (registered)
//   fifo_count bytes held in the FIFO, excluding the byte being shifted
//   overflow   sticky: a write was offered while tx_ready was low
module rs232_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT    = 8750,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter int unsigned PARITY_EN       = 0,
  parameter int unsigned STOP_BITS       = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               tx_byte,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow
);

  localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W  = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W  = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE   = BAUD_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [2:0]        STOP_LAST  = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_ready_q, tx_ready_d;
  logic             overflow_q, overflow_d;

  // Transmit engine
  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic       push_c;
  logic       pop_c;
  logic       load_c;
  logic       baud_wrap_c;
  logic [7:0] head_c;

  assign push_c = tx_valid & tx_ready_q;
  assign head_c = mem_q[rd_ptr_q];

  // Transmit FSM: next state, baud/bit counters and serial output
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    load_c      = 1'b0;
    baud_wrap_c = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_d = baud_wrap_c ? '0 : baud_q + BAUD_ONE;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          load_c = 1'b1;
        end
      end
      S_START: begin
        if (baud_wrap_c) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_wrap_c) begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (baud_wrap_c) begin
          state_d   = S_STOP;
          bit_cnt_d = 3'd0;
          tx_d      = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_wrap_c) begin
          if (bit_cnt_q == STOP_LAST) begin
            // Back-to-back frames: start the next one with no idle gap
            if (count_q != '0) begin
              load_c = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: pop the FIFO head and drive the start bit
    if (load_c) begin
      state_d   = S_START;
      shift_d   = head_c;
      parity_d  = ^head_c;
      baud_d    = '0;
      bit_cnt_d = 3'd0;
      tx_d      = 1'b0;
    end
  end

  assign pop_c = load_c;

  // FIFO pointers, occupancy, ready and overflow
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (tx_valid & ~tx_ready_q);

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    tx_ready_d = (count_d != FULL_COUNT);
    busy_d     = (state_d != S_IDLE) | (count_d != '0);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_ready_q <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_ready_q <= tx_ready_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // FIFO storage has no reset; the pointers define its contents
  always_ff @(posedge clock) begin
    if (reset && push_c) begin
      mem_q[wr_ptr_q] <= tx_byte;
    end
  end

  assign tx_ready   = tx_ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rs232_tx_encoder.sv
// Testbench for rs232_tx_encoder. Two instances with different framing
// (4 clks/bit, no parity, 1 stop; 3 clks/bit, even parity, 2 stops) are
// driven independently. Accepted bytes go into a per-instance queue; a
// monitor checks the serial line, busy, fifo_count, tx_ready and overflow
// every cycle against a frame model built from the bit layout.
module tb_rs232_tx_encoder;

  localparam int NI    = 2;
  localparam int DEPTH = 8;

  logic       clock;
  logic       reset;
  logic [7:0] tx_byte    [NI];
  logic       tx_valid   [NI];
  logic       tx_ready_w [NI];
  logic       tx_w       [NI];
  logic       busy_w     [NI];
  logic [3:0] fifo_cnt_w [NI];
  logic       ovf_w      [NI];

  rs232_tx_encoder #(
    .CLKS_PER_BIT(4), .FIFO_DEPTH_LOG2(3), .PARITY_EN(0), .STOP_BITS(1)
  ) dut0 (
    .clock(clock), .reset(reset), .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
    .fifo_count(fifo_cnt_w[0]), .overflow(ovf_w[0])
  );

  rs232_tx_encoder #(
    .CLKS_PER_BIT(3), .FIFO_DEPTH_LOG2(3), .PARITY_EN(1), .STOP_BITS(2)
  ) dut1 (
    .clock(clock), .reset(reset), .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
    .fifo_count(fifo_cnt_w[1]), .overflow(ovf_w[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", name, i, $time, act, exp);
    end
  endtask

  // Frame layout per instance
  function automatic int cpb(input int i);
    return (i == 0) ? 4 : 3;
  endfunction
  function automatic int par(input int i);
    return (i == 0) ? 0 : 1;
  endfunction
  function automatic int stp(input int i);
    return (i == 0) ? 1 : 2;
  endfunction
  function automatic int frame_len(input int i);
    return (9 + par(i) + stp(i)) * cpb(i);
  endfunction
  // Line level at cycle pos of a frame carrying d
  function automatic logic exp_bit(input int i, input logic [7:0] d, input int pos);
    int b;
    b = pos / cpb(i);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par(i) == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Expected byte queues: accepted but not yet started on the line
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  function automatic int q_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction
  task automatic q_push(input int i, input logic [7:0] d);
    if (i == 0) q0.push_back(d); else q1.push_back(d);
  endtask
  task automatic q_pop(input int i, output logic [7:0] d);
    if (i == 0) d = q0.pop_front(); else d = q1.pop_front();
  endtask
  task automatic q_clear(input int i);
    if (i == 0) q0.delete(); else q1.delete();
  endtask

  logic       rst_at_edge = 1'b0;
  int         pos [NI] = '{-1, -1};
  logic [7:0] cur [NI];
  logic       prev_pending [NI] = '{1'b0, 1'b0};
  logic       m_ready [NI] = '{1'b0, 1'b0};
  logic       m_ovf [NI] = '{1'b0, 1'b0};

  // Scoreboard push: sample the handshake as the DUT sees it on each edge
  initial begin
    forever begin
      @(posedge clock);
      rst_at_edge = reset;
      for (int i = 0; i < NI; i++) begin
        if (!reset) begin
          q_clear(i);
          m_ovf[i] = 1'b0;
        end else if (tx_valid[i]) begin
          if (m_ready[i]) q_push(i, tx_byte[i]);
          else m_ovf[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: compare all outputs every cycle on the falling edge
  initial begin
    logic in_frame;
    logic e_tx;
    forever begin
      @(negedge clock);
      for (int i = 0; i < NI; i++) begin
        in_frame = 1'b0;
        e_tx     = 1'b1;
        if (!rst_at_edge) begin
          pos[i]          = -1;
          prev_pending[i] = 1'b0;
          m_ready[i]      = 1'b0;
        end else begin
          if (pos[i] < 0 && prev_pending[i]) begin
            q_pop(i, cur[i]);
            pos[i] = 0;
          end
          if (pos[i] >= 0) begin
            in_frame = 1'b1;
            e_tx     = exp_bit(i, cur[i], pos[i]);
            pos[i]++;
            if (pos[i] == frame_len(i)) pos[i] = -1;
          end
          prev_pending[i] = (q_size(i) != 0);
          m_ready[i]      = (q_size(i) != DEPTH);
        end
        check("tx", i, int'(tx_w[i]), int'(e_tx));
        check("busy", i, int'(busy_w[i]), int'(in_frame || q_size(i) != 0));
        check("fifo_count", i, int'(fifo_cnt_w[i]), q_size(i));
        check("tx_ready", i, int'(tx_ready_w[i]), int'(m_ready[i]));
        check("overflow", i, int'(ovf_w[i]), int'(m_ovf[i]));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) tx_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && pos[0] < 0 && pos[1] < 0) && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL %s drain timeout after %0d cycles", name, budget);
    end
    repeat (3) step();
  endtask

  initial begin
    int rates [4];
    rates = '{2, 8, 40, 90};
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      tx_valid[i] = 1'b0;
      tx_byte[i]  = 8'h00;
    end
    repeat (3) step();
    reset = 1'b1;
    step();

    // Single frames: 0x55 plain, 0x07 with parity and two stop bits
    tx_valid[0] = 1'b1; tx_byte[0] = 8'h55;
    tx_valid[1] = 1'b1; tx_byte[1] = 8'h07;
    step();
    clear_inputs();
    wait_idle("single", 200);

    // Back-to-back frames from consecutive writes
    for (int i = 0; i < NI; i++) begin tx_valid[i] = 1'b1; tx_byte[i] = 8'hA5; end
    step();
    for (int i = 0; i < NI; i++) tx_byte[i] = 8'h3C;
    step();
    clear_inputs();
    wait_idle("b2b", 300);

    // Fill the FIFO while the first frame is in flight, then overrun it
    for (int k = 0; k < 11; k++) begin
      for (int i = 0; i < NI; i++) begin
        tx_valid[i] = 1'b1;
        tx_byte[i]  = 8'(8'h10 * (i + 1) + k);
      end
      step();
    end
    for (int i = 0; i < NI; i++) begin
      check("full_count", i, int'(fifo_cnt_w[i]), 8);
      check("full_ready", i, int'(tx_ready_w[i]), 0);
      check("full_ovf", i, int'(ovf_w[i]), 1);
    end
    clear_inputs();
    wait_idle("full", 1500);

    // Reset during data bit 3 with two bytes queued
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NI; i++) begin tx_valid[i] = 1'b1; tx_byte[i] = 8'(8'hC0 + k); end
      step();
    end
    clear_inputs();
    repeat (16) step();
    reset = 1'b0;
    step();
    for (int i = 0; i < NI; i++) begin
      check("rst_tx", i, int'(tx_w[i]), 1);
      check("rst_busy", i, int'(busy_w[i]), 0);
      check("rst_count", i, int'(fifo_cnt_w[i]), 0);
      check("rst_ovf", i, int'(ovf_w[i]), 0);
    end
    reset = 1'b1;
    step();
    repeat (60) step();

    // Random traffic with varying offered load
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NI; i++) begin
        tx_valid[i] = ($urandom_range(0, 99) < rates[(k / 400) % 4]);
        tx_byte[i]  = 8'($urandom_range(0, 255));
      end
      step();
    end
    clear_inputs();
    wait_idle("random", 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
